// File: rtl/i2c_pkg.sv
// i2c_pkg: shared constants for the I2C target back end (state encoding, widths, defaults).
package i2c_pkg;
   localparam int DATA_W = 8;
   localparam logic [6:0] DEV_ADDR = 7'h50;
   localparam logic [DATA_W-1:0] RESET_VAL_DEF = 8'h00;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PTR   = 2'd1;
   localparam logic [1:0] WDATA = 2'd2;
   localparam logic [1:0] RDATA = 2'd3;
endpackage

// File: rtl/i2c_regfile.sv
// i2c_regfile: register bank behind the I2C target; pointer byte then data writes, reads on request.
// Define I2C_REGFILE_AUTOINC_EN to advance the pointer after every data write and read.
module i2c_regfile
   import i2c_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter logic [DATA_W-1:0] RESET_VAL = RESET_VAL_DEF
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            txn_start,
   input  logic                            txn_read,
   input  logic                            txn_stop,
   input  logic                            wr_valid,
   input  logic [DATA_W-1:0]               wr_data,
   input  logic                            rd_req,
   output logic [DATA_W-1:0]               rd_data,
   output logic                            rd_valid,
   output logic [DATA_W*(2**ADDR_W)-1:0]   reg_out,
   output logic                            wr_strobe,
   output logic [ADDR_W-1:0]               wr_idx,
   output logic [ADDR_W-1:0]               ptr
);
   localparam int DEPTH = 2**ADDR_W;
   logic [1:0] state;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [ADDR_W-1:0] ptr_adv;
`ifdef I2C_REGFILE_AUTOINC_EN
   assign ptr_adv = ptr + ADDR_W'(1);
`else
   assign ptr_adv = ptr;
`endif
   for (genvar g = 0; g < DEPTH; g++) begin : g_out
      assign reg_out[DATA_W*g +: DATA_W] = regs[g];
   end
   // Transaction markers outrank data, so a byte coinciding with START/STOP is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         ptr       <= '0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         wr_strobe <= 1'b0;
         wr_idx    <= '0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
      end else begin
         wr_strobe <= 1'b0;
         rd_valid  <= 1'b0;
         if (txn_start) state <= txn_read ? RDATA : PTR;
         else if (txn_stop) state <= IDLE;
         else if (wr_valid && state == PTR) begin
            ptr   <= wr_data[ADDR_W-1:0];
            state <= WDATA;
         end else if (wr_valid && state == WDATA) begin
            regs[ptr] <= wr_data;
            wr_strobe <= 1'b1;
            wr_idx    <= ptr;
            ptr       <= ptr_adv;
         end else if (rd_req && state == RDATA) begin
            rd_data  <= regs[ptr];
            rd_valid <= 1'b1;
            ptr      <= ptr_adv;
         end
      end
   end
endmodule

// File: tb/tb_i2c_regfile.sv
// tb_i2c_regfile: directed stimulus with a queue scoreboard for write strobes and read returns.
// Expected values follow I2C_REGFILE_AUTOINC_EN when it is defined.
module tb_i2c_regfile;
   localparam int AW = 3;
`ifdef I2C_REGFILE_AUTOINC_EN
   localparam bit AI = 1'b1;
`else
   localparam bit AI = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b0;
   logic txn_start = 0, txn_read = 0, txn_stop = 0, wr_valid = 0, rd_req = 0;
   logic [7:0] wr_data = 8'h00;
   logic [7:0] rd_data;
   logic rd_valid, wr_strobe;
   logic [63:0] reg_out;
   logic [AW-1:0] wr_idx, ptr;
   int checks = 0, failures = 0, cyc = 0;
   logic [10:0] wq[$];
   int wcq[$];
   logic [7:0] rq[$];
   int rcq[$];

   i2c_regfile #(.ADDR_W(AW), .RESET_VAL(8'h00)) dut (
      .clk(clk), .reset(reset), .txn_start(txn_start), .txn_read(txn_read),
      .txn_stop(txn_stop), .wr_valid(wr_valid), .wr_data(wr_data), .rd_req(rd_req),
      .rd_data(rd_data), .rd_valid(rd_valid), .reg_out(reg_out),
      .wr_strobe(wr_strobe), .wr_idx(wr_idx), .ptr(ptr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drv(input logic s, input logic r, input logic sp, input logic wv,
                      input logic [7:0] wd, input logic rqs);
      txn_start = s; txn_read = r; txn_stop = sp; wr_valid = wv; wr_data = wd; rd_req = rqs;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 8'h00, 0);
   endtask

   task automatic wbyte(input logic [7:0] b);
      drv(0, 0, 0, 1, b, 0);
   endtask

   task automatic wdat(input logic [2:0] idx, input logic [7:0] b);
      wq.push_back({idx, b});
      wcq.push_back(cyc + 1);
      drv(0, 0, 0, 1, b, 0);
   endtask

   task automatic rdreq(input logic [7:0] exp);
      rq.push_back(exp);
      rcq.push_back(cyc + 1);
      drv(0, 0, 0, 0, 8'h00, 1);
   endtask

   initial begin
      logic [10:0] e;
      logic [7:0] d;
      int c;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (wr_strobe) begin
            if (wq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_wr_strobe: got idx %0d expected no strobe", wr_idx);
            end else begin
               e = wq.pop_front();
               c = wcq.pop_front();
               chk("wr_idx", 64'(wr_idx), 64'(e[10:8]));
               chk("wr_reg_byte", 64'(reg_out[8*e[10:8] +: 8]), 64'(e[7:0]));
               chk("wr_strobe_cycle", 64'(cyc), 64'(c));
            end
         end
         if (rd_valid) begin
            if (rq.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_rd_valid: got data %h expected no rd_valid", rd_data);
            end else begin
               d = rq.pop_front();
               c = rcq.pop_front();
               chk("rd_data", 64'(rd_data), 64'(d));
               chk("rd_valid_cycle", 64'(cyc), 64'(c));
            end
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b1;
      idle(1);
      chk("reset_reg_out", reg_out, 64'h0);
      chk("reset_ptr", 64'(ptr), 64'd0);
      chk("reset_rd_valid", 64'(rd_valid), 64'd0);
      chk("reset_wr_strobe", 64'(wr_strobe), 64'd0);
      // write burst
      drv(1, 0, 0, 0, 8'h00, 0);
      wbyte(8'h02);
      wdat(3'd2, 8'hA5);
      wdat(AI ? 3'd3 : 3'd2, 8'h5A);
      drv(0, 0, 1, 0, 8'h00, 0);
      idle(1);
      chk("burst_reg2", 64'(reg_out[23:16]), AI ? 64'hA5 : 64'h5A);
      chk("burst_reg3", 64'(reg_out[31:24]), AI ? 64'h5A : 64'h00);
      chk("burst_ptr", 64'(ptr), AI ? 64'd4 : 64'd2);
      // pointer wrap
      drv(1, 0, 0, 0, 8'h00, 0);
      wbyte(8'h07);
      wdat(3'd7, 8'h11);
      wdat(AI ? 3'd0 : 3'd7, 8'h22);
      drv(0, 0, 1, 0, 8'h00, 0);
      idle(1);
      chk("wrap_reg7", 64'(reg_out[63:56]), AI ? 64'h11 : 64'h22);
      chk("wrap_reg0", 64'(reg_out[7:0]), AI ? 64'h22 : 64'h00);
      chk("wrap_ptr", 64'(ptr), AI ? 64'd1 : 64'd7);
      // repeated-start reads
      drv(1, 0, 0, 0, 8'h00, 0);
      wbyte(8'h03);
      drv(1, 1, 0, 0, 8'h00, 0);
      rdreq(AI ? 8'h5A : 8'h00);
      rdreq(8'h00);
      drv(1, 0, 0, 0, 8'h00, 0);
      wbyte(8'h07);
      drv(1, 1, 0, 0, 8'h00, 0);
      rdreq(AI ? 8'h11 : 8'h22);
      idle(1);
      rdreq(AI ? 8'h22 : 8'h22);
      drv(0, 0, 1, 0, 8'h00, 0);
      idle(3);
      chk("rd_data_hold", 64'(rd_data), 64'h22);
      chk("read_ptr", 64'(ptr), AI ? 64'd1 : 64'd7);
      // ignored traffic: byte/read in IDLE, byte with STOP, byte with START
      wbyte(8'h99);
      drv(0, 0, 0, 0, 8'h00, 1);
      drv(1, 0, 0, 0, 8'h00, 0);
      wbyte(8'h01);
      drv(0, 0, 1, 1, 8'h77, 0);
      drv(1, 0, 0, 1, 8'h06, 0);
      wbyte(8'h05);
      wdat(3'd5, 8'hC3);
      drv(0, 0, 1, 0, 8'h00, 0);
      idle(1);
      chk("ignored_reg_out", reg_out,
          AI ? 64'h1100C3005AA50022 : 64'h2200C30000_5A0000);
      chk("ignored_ptr", 64'(ptr), AI ? 64'd6 : 64'd5);
      // pointer masking
      drv(1, 0, 0, 0, 8'h00, 0);
      wbyte(8'hFD);
      drv(0, 0, 1, 0, 8'h00, 0);
      idle(1);
      chk("mask_ptr", 64'(ptr), 64'd5);
      // reset mid-write
      drv(1, 0, 0, 0, 8'h00, 0);
      wbyte(8'h04);
      txn_start = 0; wr_valid = 1; wr_data = 8'hEE; reset = 1'b0;
      @(negedge clk);
      wr_valid = 0;
      @(negedge clk);
      chk("midreset_reg_out", reg_out, 64'h0);
      chk("midreset_ptr", 64'(ptr), 64'd0);
      chk("midreset_rd_valid", 64'(rd_valid), 64'd0);
      chk("midreset_wr_strobe", 64'(wr_strobe), 64'd0);
      reset = 1'b1;
      idle(3);
      chk("wr_queue_drained", 64'(wq.size()), 64'd0);
      chk("rd_queue_drained", 64'(rq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
